axi_lite_reg_arbiter: RTL

- Shares the single AXI4-Lite register port of the MAC configuration space between two independent register requesters, e.g. the init sequencer and the runtime stats/MDIO poller.
- Each requester uses a simple req/ack word-access interface. The arbiter grants round-robin and runs one complete AXI4-Lite transaction at a time: AW+W then B for writes, AR then R for reads.
- It returns read data and response status to the granted requester.

---
 rtl/axi_lite_reg_arbiter.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite register port between two
// req/ack word requesters; one full AXI transaction in flight at a time.
// Ports: Clk_reg, Reset (sync, active-high); Req{0,1}/_we/_addr/_wdata in,
// Ack{0,1}/Rdata{0,1}/Err{0,1} out; S_AXI_* AXI4-Lite master channel.
// Optional macro AXI_ARB_TIMEOUT_EN: abort after TMO_CYC stalled cycles.
module axi_lite_reg_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              Clk_reg,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req0_we,
  input  logic [ADDR_W-1:0] Req0_addr,
  input  logic [DATA_W-1:0] Req0_wdata,
  input  logic              Req1,
  input  logic              Req1_we,
  input  logic [ADDR_W-1:0] Req1_addr,
  input  logic [DATA_W-1:0] Req1_wdata,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] Rdata0,
  output logic [DATA_W-1:0] Rdata1,
  output logic              Err0,
  output logic              Err1,
  output logic [31:0]       S_AXI_awaddr,
  output logic              S_AXI_awvalid,
  input  logic              S_AXI_awready,
  output logic [DATA_W-1:0] S_AXI_wdata,
  output logic              S_AXI_wvalid,
  input  logic              S_AXI_wready,
  input  logic              S_AXI_bvalid,
  input  logic [1:0]        S_AXI_bresp,
  output logic              S_AXI_bready,
  output logic [31:0]       S_AXI_araddr,
  output logic              S_AXI_arvalid,
  input  logic              S_AXI_arready,
  input  logic              S_AXI_rvalid,
  input  logic [1:0]        S_AXI_rresp,
  input  logic [DATA_W-1:0] S_AXI_rdata,
  output logic              S_AXI_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                gnt_q, gnt_d;
  logic [31:0]         awaddr_q, awaddr_d;
  logic                awvalid_q, awvalid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic [31:0]         araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;

  logic                sel;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [31:0]         sel_baddr;

  // Transaction completion bundle, shared by normal and timeout paths.
  logic                fin;
  logic                fin_err;
  logic                fin_rd;
  logic [DATA_W-1:0]   fin_rdata;

  // Both requesting: rr pointer decides; otherwise whoever asks.
  assign sel       = (Req0 & Req1) ? rr_q : Req1;
  assign sel_we    = sel ? Req1_we    : Req0_we;
  assign sel_addr  = sel ? Req1_addr  : Req0_addr;
  assign sel_wdata = sel ? Req1_wdata : Req0_wdata;
  assign sel_baddr = {{(30-ADDR_W){1'b0}}, sel_addr, 2'b00};

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;
  assign busy = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rd    = 1'b0;
    fin_rdata = '0;
`ifdef AXI_ARB_TIMEOUT_EN
    cnt_d     = cnt_q + CNT_W'(1);
`endif

    unique case (state_q)
      S_IDLE: begin
        if (Req0 | Req1) begin
          gnt_d = sel;
          rr_d  = ~sel;
          if (sel_we) begin
            awaddr_d  = sel_baddr;
            wdata_d   = sel_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            araddr_d  = sel_baddr;
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        if (awvalid_q & S_AXI_awready) begin
          awvalid_d = 1'b0;
          awaddr_d  = '0;
        end
        if (wvalid_q & S_AXI_wready) begin
          wvalid_d = 1'b0;
          wdata_d  = '0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (S_AXI_bvalid) begin
          bready_d = 1'b0;
          fin      = 1'b1;
          fin_err  = |S_AXI_bresp;
        end
      end
      S_RD_ADDR: begin
        if (S_AXI_arready) begin
          arvalid_d = 1'b0;
          araddr_d  = '0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (S_AXI_rvalid) begin
          rready_d  = 1'b0;
          fin       = 1'b1;
          fin_rd    = 1'b1;
          fin_err   = |S_AXI_rresp;
          fin_rdata = S_AXI_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_ARB_TIMEOUT_EN
    // Abort only if the state made no progress this cycle.
    if (busy && !fin && state_d == state_q &&
        cnt_q == CNT_W'(TMO_CYC - 1)) begin
      awvalid_d = 1'b0;
      awaddr_d  = '0;
      wvalid_d  = 1'b0;
      wdata_d   = '0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      araddr_d  = '0;
      rready_d  = 1'b0;
      fin       = 1'b1;
      fin_err   = 1'b1;
      fin_rd    = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
      fin_rdata = DATA_W'(32'hDEAD_BEEF);
    end
`endif

    // Ack is raised entering DONE so it is high during the DONE cycle.
    if (fin) begin
      state_d = S_DONE;
      if (gnt_q) begin
        ack1_d = 1'b1;
        err1_d = fin_err;
        if (fin_rd) rdata1_d = fin_rdata;
      end else begin
        ack0_d = 1'b1;
        err0_d = fin_err;
        if (fin_rd) rdata0_d = fin_rdata;
      end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    if (state_d != state_q) cnt_d = '0;
`endif
  end

  always_ff @(posedge Clk_reg) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
`ifdef AXI_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign Ack0          = ack0_q;
  assign Ack1          = ack1_q;
  assign Rdata0        = rdata0_q;
  assign Rdata1        = rdata1_q;
  assign Err0          = err0_q;
  assign Err1          = err1_q;
  assign S_AXI_awaddr  = awaddr_q;
  assign S_AXI_awvalid = awvalid_q;
  assign S_AXI_wdata   = wdata_q;
  assign S_AXI_wvalid  = wvalid_q;
  assign S_AXI_bready  = bready_q;
  assign S_AXI_araddr  = araddr_q;
  assign S_AXI_arvalid = arvalid_q;
  assign S_AXI_rready  = rready_q;

endmodule
